// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into single SETUP->ACCESS transfers, one outstanding.
// Optional ACCESS wait-state timeout is built in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             rsp_timeout_q, rsp_timeout_nxt;

  // Expiry fires on the edge that would make the count reach TIMEOUT_CYCLES; pready=1 there wins.
  assign timeout_hit = (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    wait_cnt_nxt    = '0;
    rsp_timeout_nxt = timeout_hit;
    if ((state == ACCESS) && !pready && !timeout_hit)
      wait_cnt_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Held low through reset so no command can be taken while the bus is being cleared.
  assign cmd_ready = presetn && (state == IDLE);

  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_nxt   = cmd_addr;
          pwrite_nxt  = cmd_write;
          pwdata_nxt  = cmd_write ? cmd_wdata : '0;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = pslverr;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
          state_nxt     = IDLE;
        end else if (timeout_hit) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule
